// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store bridge from the pipeline to the SRAM arbiter
// read/write channels with size encoding, issue handshake, timeout and load extension.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] rd_address,
  output logic [1:0]  rd_sig_read,
  input  logic [31:0] rd_data,
  input  logic        rd_is_ready,
  output logic [31:0] wr_address,
  output logic [1:0]  wr_sig_write,
  output logic [31:0] wr_data,
  input  logic        wr_is_ready
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, WAIT_FREE, ISSUE, WAIT_DONE, RESP} state_t;
  state_t state, state_n;
  logic write_q, signed_q;
  logic [1:0] size_q;
  logic [31:0] addr_q, wdata_q, ext;
  logic [CW-1:0] cnt;
  logic accept, ready_sel, timeout, done;
  assign accept = req_valid && state == IDLE;
  assign ready_sel = write_q ? wr_is_ready : rd_is_ready;
  assign timeout = cnt == CW'(TIMEOUT_CYCLES - 1);
  // completion wins over a timeout landing in the same cycle
  assign done = state == WAIT_DONE && (ready_sel || timeout);
  assign ext = size_q == 2'd1 ? {{24{signed_q & rd_data[7]}}, rd_data[7:0]} :
               size_q == 2'd2 ? {{16{signed_q & rd_data[15]}}, rd_data[15:0]} : rd_data;
  assign req_ready = state == IDLE;
  assign resp_valid = state == RESP;
  assign rd_sig_read = (state == ISSUE && !write_q) ? size_q : 2'd0;
  assign wr_sig_write = (state == ISSUE && write_q) ? size_q : 2'd0;
  assign rd_address = addr_q;
  assign wr_address = addr_q;
  assign wr_data = wdata_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:      state_n = !req_valid ? IDLE : (req_size == 2'd0 ? RESP : WAIT_FREE);
      WAIT_FREE: state_n = ready_sel ? ISSUE : WAIT_FREE;
      ISSUE:     state_n = WAIT_DONE;
      WAIT_DONE: state_n = (ready_sel || timeout) ? RESP : WAIT_DONE;
      default:   state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_q <= 1'b0;
      signed_q <= 1'b0;
      size_q <= 2'd0;
      addr_q <= 32'd0;
      wdata_q <= 32'd0;
      cnt <= '0;
      resp_rdata <= 32'd0;
      resp_error <= 1'b0;
    end else begin
      if (accept) begin
        write_q <= req_write;
        signed_q <= req_signed;
        size_q <= req_size;
        addr_q <= req_addr;
        wdata_q <= req_wdata;
        resp_rdata <= 32'd0;
        resp_error <= req_size == 2'd0;
      end
      cnt <= state == ISSUE ? '0 : state == WAIT_DONE ? cnt + 1'b1 : cnt;
      if (done) begin
        resp_rdata <= (ready_sel && !write_q) ? ext : 32'd0;
        resp_error <= !ready_sel;
      end
      if (state == RESP) begin
        resp_rdata <= 32'd0;
        resp_error <= 1'b0;
      end
    end
  end
endmodule
